// File: rtl/vcache_stat_pkg.sv
// Purpose : shared constants and types for the vcache statistics streamer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: frame length, word-index and FSM state enums, header field
//           offsets, and the packed snapshot record held during a frame.
package vcache_stat_pkg;

  // Width of every live/shadow statistic counter.
  localparam int unsigned STAT_W = 32;

  // Words per frame: header, global_ctr, tag, six counters.
  localparam int unsigned FRAME_LEN = 9;

  // Header word layout (bits [31:0]; any upper bits are zero).
  localparam int unsigned HDR_DROP_BIT = 0;
  localparam int unsigned HDR_ID_LSB   = 16;
  localparam int unsigned HDR_ID_W     = 16;

  typedef enum logic [3:0] {
    W_HDR     = 4'd0,
    W_GCTR    = 4'd1,
    W_TAG     = 4'd2,
    W_LD      = 4'd3,
    W_ST      = 4'd4,
    W_LD_MISS = 4'd5,
    W_ST_MISS = 4'd6,
    W_DMA_RD  = 4'd7,
    W_DMA_WR  = 4'd8
  } word_idx_e;

  localparam word_idx_e W_LAST = word_idx_e'(4'(FRAME_LEN - 1));

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  typedef struct packed {
    logic [STAT_W-1:0] gctr;
    logic [STAT_W-1:0] ld;
    logic [STAT_W-1:0] st;
    logic [STAT_W-1:0] ld_miss;
    logic [STAT_W-1:0] st_miss;
    logic [STAT_W-1:0] dma_rd;
    logic [STAT_W-1:0] dma_wr;
  } snap_t;

endpackage

// File: rtl/vcache_stat_counter.sv
// Purpose : 32-bit saturating event counter with optional synchronous load.
// Latency : count visible on cnt_o the cycle after inc_i/load_i.
// Backpressure: none; every strobe is counted (load takes priority over inc).
// Ports   : clk_i, reset_n_i (async active-low), inc_i, load_i, load_val_i,
//           cnt_o (registered count).
module vcache_stat_counter
  import vcache_stat_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [STAT_W-1:0] load_val_i,
  output logic [STAT_W-1:0] cnt_o
);

  logic [STAT_W-1:0] cnt_q;
  logic [STAT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != {STAT_W{1'b1}})) begin
      // Stick at all-ones rather than wrapping to zero.
      cnt_d = cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vcache_stat_streamer.sv
// Purpose : counts vcache/DMA events and streams a 9-word snapshot frame on request.
// Latency : first frame word valid the cycle after the request is accepted.
// Backpressure: words hold while ready_i=0; requests during a frame are dropped and flagged.
// Ports   : clk_i, reset_n_i (async active-low); ev_*_i event strobes; global_ctr_i;
//           print_stat_v_i/print_stat_tag_i/print_stat_ready_o request side;
//           v_o/data_o/last_o/ready_i frame output side.
// Config  : define VCACHE_STAT_CLEAR_ON_SNAP_EN to restart the live counters on each
//           accepted snapshot; otherwise the counters are cumulative.
module vcache_stat_streamer
  import vcache_stat_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int id_p         = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    ev_ld_i,
  input  logic                    ev_st_i,
  input  logic                    ev_ld_miss_i,
  input  logic                    ev_st_miss_i,
  input  logic                    ev_dma_rd_i,
  input  logic                    ev_dma_wr_i,
  input  logic [31:0]             global_ctr_i,
  input  logic                    print_stat_v_i,
  input  logic [data_width_p-1:0] print_stat_tag_i,
  output logic                    print_stat_ready_o,
  output logic                    v_o,
  output logic [data_width_p-1:0] data_o,
  output logic                    last_o,
  input  logic                    ready_i
);

  state_e                  state_q, state_d;
  word_idx_e               idx_q, idx_d;
  logic                    drop_q, drop_d;
  snap_t                   snap_q, snap_d;
  logic [data_width_p-1:0] tag_q, tag_d;

  logic accept;
  logic hs;
  logic snap_load;

  logic [STAT_W-1:0] ld_cnt, st_cnt, ld_miss_cnt, st_miss_cnt, dma_rd_cnt, dma_wr_cnt;

  assign accept = print_stat_v_i & print_stat_ready_o;
  assign hs     = v_o & ready_i;

`ifdef VCACHE_STAT_CLEAR_ON_SNAP_EN
  // Restart counting at the snapshot; a same-cycle strobe becomes the first count.
  assign snap_load = accept;
`else
  assign snap_load = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Live counters
  // ---------------------------------------------------------------------------
  vcache_stat_counter u_ld_ctr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (ev_ld_i),
    .load_i     (snap_load),
    .load_val_i ({{(STAT_W-1){1'b0}}, ev_ld_i}),
    .cnt_o      (ld_cnt)
  );

  vcache_stat_counter u_st_ctr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (ev_st_i),
    .load_i     (snap_load),
    .load_val_i ({{(STAT_W-1){1'b0}}, ev_st_i}),
    .cnt_o      (st_cnt)
  );

  vcache_stat_counter u_ld_miss_ctr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (ev_ld_miss_i),
    .load_i     (snap_load),
    .load_val_i ({{(STAT_W-1){1'b0}}, ev_ld_miss_i}),
    .cnt_o      (ld_miss_cnt)
  );

  vcache_stat_counter u_st_miss_ctr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (ev_st_miss_i),
    .load_i     (snap_load),
    .load_val_i ({{(STAT_W-1){1'b0}}, ev_st_miss_i}),
    .cnt_o      (st_miss_cnt)
  );

  vcache_stat_counter u_dma_rd_ctr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (ev_dma_rd_i),
    .load_i     (snap_load),
    .load_val_i ({{(STAT_W-1){1'b0}}, ev_dma_rd_i}),
    .cnt_o      (dma_rd_cnt)
  );

  vcache_stat_counter u_dma_wr_ctr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (ev_dma_wr_i),
    .load_i     (snap_load),
    .load_val_i ({{(STAT_W-1){1'b0}}, ev_dma_wr_i}),
    .cnt_o      (dma_wr_cnt)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SEND;
      ST_SEND: if (hs && (idx_q == W_LAST)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // Ready is gated by reset so nothing is offered while held in reset.
    print_stat_ready_o = (state_q == ST_IDLE) & reset_n_i;
    v_o                = (state_q == ST_SEND);
    last_o             = (state_q == ST_SEND) & (idx_q == W_LAST);
  end

  // ---------------------------------------------------------------------------
  // Word index, drop flag, snapshot shadow
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d = idx_q;
    if (hs) begin
      idx_d = (idx_q == W_LAST) ? W_HDR : word_idx_e'(idx_q + 4'd1);
    end
  end

  always_comb begin
    drop_d = drop_q;
    // A request seen mid-frame wins over clearing on the header handshake.
    if (print_stat_v_i && (state_q == ST_SEND)) begin
      drop_d = 1'b1;
    end else if (hs && (idx_q == W_HDR)) begin
      drop_d = 1'b0;
    end
  end

  always_comb begin
    snap_d = snap_q;
    tag_d  = tag_q;
    if (accept) begin
      // Counter outputs are registered, so these are the pre-increment values.
      snap_d.gctr    = global_ctr_i;
      snap_d.ld      = ld_cnt;
      snap_d.st      = st_cnt;
      snap_d.ld_miss = ld_miss_cnt;
      snap_d.st_miss = st_miss_cnt;
      snap_d.dma_rd  = dma_rd_cnt;
      snap_d.dma_wr  = dma_wr_cnt;
      tag_d          = print_stat_tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx_q  <= W_HDR;
      drop_q <= 1'b0;
      snap_q <= '0;
      tag_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      drop_q <= drop_d;
      snap_q <= snap_d;
      tag_q  <= tag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output word mux (32-bit fields zero-extended to data_width_p)
  // ---------------------------------------------------------------------------
  always_comb begin
    data_o = '0;
    case (idx_q)
      W_HDR: begin
        data_o[HDR_ID_LSB +: HDR_ID_W] = 16'(id_p);
        data_o[HDR_DROP_BIT]           = drop_q;
      end
      W_GCTR:    data_o[STAT_W-1:0] = snap_q.gctr;
      W_TAG:     data_o             = tag_q;
      W_LD:      data_o[STAT_W-1:0] = snap_q.ld;
      W_ST:      data_o[STAT_W-1:0] = snap_q.st;
      W_LD_MISS: data_o[STAT_W-1:0] = snap_q.ld_miss;
      W_ST_MISS: data_o[STAT_W-1:0] = snap_q.st_miss;
      W_DMA_RD:  data_o[STAT_W-1:0] = snap_q.dma_rd;
      W_DMA_WR:  data_o[STAT_W-1:0] = snap_q.dma_wr;
      default:   data_o             = '0;
    endcase
  end

endmodule

// File: doc/vcache_stat_streamer.md
VCACHE_STAT_STREAMER -- requirements
Module: vcache_stat_streamer

Interface
REQ-001 Parameter: data_width_p, default 32, width of the print tag and every output word; must be >= 32.
REQ-002 Parameter: id_p, default 0, instance identifier placed in the header word, 16 bits used.
REQ-003 Port: clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset_n_i  input  1  reset, asynchronous assert and active-low; synchronous deassert is the integrator's responsibility.
REQ-005 Ports: ev_ld_i, ev_st_i, ev_ld_miss_i, ev_st_miss_i, ev_dma_rd_i, ev_dma_wr_i  input  1 each  pre-qualified one-cycle event strobes from the vcache pipeline and DMA interface.
REQ-006 Port: global_ctr_i  input  32  free-running global cycle counter.
REQ-007 Port: print_stat_v_i  input  1  snapshot request.
REQ-008 Port: print_stat_tag_i  input  data_width_p  tag carried with the request.
REQ-009 Port: print_stat_ready_o  output  1  request accepted when high with print_stat_v_i.
REQ-010 Port: v_o  output  1  output word valid.
REQ-011 Port: data_o  output  data_width_p  output word.
REQ-012 Port: last_o  output  1  marks final word of a frame.
REQ-013 Port: ready_i  input  1  consumer accepts word when high with v_o.

Function
REQ-014 Six live 32-bit counters (ld, st, ld_miss, st_miss, dma_rd, dma_wr) SHALL each increment by 1 on their strobe, saturating at 0xFFFF_FFFF.
REQ-015 FSM SHALL have states IDLE and SEND; print_stat_ready_o = 1 only in IDLE.
REQ-016 On request accept in cycle N: capture global_ctr_i, tag, and the six counters' pre-increment values into a shadow; enter SEND; v_o = 1 from cycle N+1.
REQ-017 A strobe in the accept cycle SHALL be excluded from the snapshot and counted in the live counter.
REQ-018 Frame: 9 words, in order header, global_ctr, tag, ld, st, ld_miss, st_miss, dma_rd, dma_wr; 32-bit values zero-extended to data_width_p.
REQ-019 Header = {id_p[15:0], 15 zero bits, drop_r} in bits [31:0]; upper bits zero.
REQ-020 Each word SHALL hold stable while v_o=1 and ready_i=0; the index advances only on v_o & ready_i.
REQ-021 last_o = 1 exactly when v_o=1 and index = 8; on that handshake, return to IDLE; the next accept is possible no earlier than the following cycle.
REQ-022 print_stat_v_i=1 while in SEND SHALL set sticky drop_r; drop_r clears on header handshake unless a new drop occurs in that same cycle (set wins).
REQ-023 ready_i held low indefinitely SHALL not lose or corrupt any state; live counting continues.

Reset
REQ-024 While reset_n_i=0: state IDLE, index 0, v_o=0, last_o=0, print_stat_ready_o=0, drop_r=0, live and shadow counters 0.
REQ-025 Reset mid-frame SHALL abort the frame immediately with no further words emitted; print_stat_ready_o=1 the first cycle after deassert.

Configuration
REQ-026 Macro VCACHE_STAT_CLEAR_ON_SNAP_EN defined: on accept, live counters load 0, or 1 where a strobe is present that cycle; undefined: live counters are untouched by snapshots (cumulative).

Structure
REQ-027 Package vcache_stat_pkg SHALL hold the frame-length constant (9), word-index enum, state enum, and header field offsets.
REQ-028 Sub-module vcache_stat_counter (32-bit saturating counter with inc and optional load) SHALL be instantiated six times.

Verification
REQ-029 3 ld strobes, 1 st_miss, then request tag=0x5A, ready_i=1 -> 9 words on consecutive cycles: header 0x0000_0000 (id_p=0), ctr, 0x5A, 3,0,0,1,0,0; last_o on word 9.
REQ-030 ready_i toggles 1,0,0,1 during frame -> each word holds while stalled; no duplicates or skips.
REQ-031 Second request mid-frame -> ignored; next frame header bit0=1; third frame bit0=0.
REQ-032 Preload ld count 0xFFFF_FFFE, 5 strobes -> reported 0xFFFF_FFFF.
REQ-033 ld strobe in accept cycle with ld=7 -> frame reports 7; next frame reports 8 (cumulative) or 1 (with VCACHE_STAT_CLEAR_ON_SNAP_EN).
REQ-034 Assert reset_n_i at word 4 -> v_o=0 at once; after deassert, print_stat_ready_o=1 and all counters report 0.
